// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle multiply/divide unit owning the HI/LO registers.
// One multiplier/quotient bit per cycle: IDLE -> RUN (32 cycles) -> FIX -> IDLE.
// Optional feature macro: MULDIV_DIV_EN enables DIV/DIVU; without it only
// MULT/MULTU are accepted and divide issues are ignored.
module hilo_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    logic [WIDTH-1:0] ma, mb;
    logic [AW-1:0]    acc;
    logic [CW-1:0]    count;
    logic             neg_q;

    logic             sgn_op;
    logic             accept;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [AW-1:0]    mul_next;
    logic [AW-1:0]    prod_fix;

`ifdef MULDIV_DIV_EN
    logic             is_div;
    logic             neg_r;
    logic             bzero;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
`endif

    // Issue decode, magnitudes, and per-cycle datapath steps
    always_comb begin
        sgn_op   = ~op[0];
`ifdef MULDIV_DIV_EN
        accept   = start && (state == IDLE);
`else
        accept   = start && (state == IDLE) && !op[1];
`endif
        abs_a    = (sgn_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        abs_b    = (sgn_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        mul_next = {acc[AW-2:0], 1'b0} + (mb[count] ? {WIDTH'(0), ma} : AW'(0));
        prod_fix = neg_q ? (~acc + AW'(1)) : acc;
`ifdef MULDIV_DIV_EN
        trial     = {acc[AW-1:WIDTH], ma[count]};
        diff      = trial - {1'b0, mb};
        ge        = (trial >= {1'b0, mb});
        rem_next  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_next = acc[WIDTH-1:0] | (WIDTH'(ge) << count);
        quot_fix  = bzero ? {WIDTH{1'b1}}
                  : (neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0]);
        rem_fix   = neg_r ? (~acc[AW-1:WIDTH] + WIDTH'(1)) : acc[AW-1:WIDTH];
`endif
    end

    // Sequencer, accumulator and architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            count <= '0;
            neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            neg_r  <= 1'b0;
            bzero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        ma    <= abs_a;
                        mb    <= abs_b;
                        acc   <= '0;
                        count <= CW'(WIDTH - 1);
                        neg_q <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef MULDIV_DIV_EN
                        is_div <= op[1];
                        neg_r  <= sgn_op && a[WIDTH-1];
                        bzero  <= (b == '0);
`endif
                    end
                end
                RUN: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) acc <= {rem_next, quot_next};
                    else        acc <= mul_next;
`else
                    acc <= mul_next;
`endif
                    if (count == '0) state <= FIX;
                    else             count <= count - CW'(1);
                end
                FIX: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[AW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
`else
                    hi <= prod_fix[AW-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int bad_busy;
    logic busy_e0;
    logic [31:0] fact;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start before edge E0; returns sampled busy just after E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        busy_e0 = busy;
        cyc = 1;
        bad_busy = 0;
    endtask

    // Wait for done, counting edges from E0 (inclusive); bounded.
    task automatic wait_done();
        while (!done && cyc < 100) begin
            if (busy !== 1'b1) bad_busy++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // MULTU max*max, with latency and busy profile
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_busy_e0", {31'b0, busy_e0}, 32'h1);
        wait_done();
        check("multu_latency", 32'(cyc), 32'd34);
        check("multu_busy_between", 32'(bad_busy), 32'd0);
        check("multu_busy_at_done", {31'b0, busy}, 32'h0);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, done}, 32'h0);

        // MULT signed, then back-to-back issue during the done cycle
        issue(MULT, 32'hFFFFFFFD, 32'd5);
        wait_done();
        check("mult_done", {31'b0, done}, 32'h1);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);
        issue(MULT, 32'h80000000, 32'd2);
        check("b2b_accepted", {31'b0, busy_e0}, 32'h1);
        wait_done();
        check("b2b_latency", 32'(cyc), 32'd34);
        check("b2b_hi", hi, 32'hFFFFFFFF);
        check("b2b_lo", lo, 32'h00000000);

        // Factorial 12 by chained MULTU
        fact = 32'd1;
        for (int i = 2; i <= 12; i++) begin
            issue(MULTU, fact, 32'(i));
            wait_done();
            fact = lo;
        end
        check("fact12_lo", lo, 32'h1C8CFC00);
        check("fact12_hi", hi, 32'h0);

`ifdef MULDIV_DIV_EN
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done();
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        issue(DIVU, 32'd100, 32'd0);
        wait_done();
        check("divu0_latency", 32'(cyc), 32'd34);
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'd100);
        issue(DIV, 32'hFFFFFFFB, 32'd0);
        wait_done();
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'hFFFFFFFB);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done();
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h0);
        issue(DIVU, 32'd1000, 32'd7);
        wait_done();
        check("divu_lo", lo, 32'd142);
        check("divu_hi", hi, 32'd6);
`else
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        check("nodiv_busy", {31'b0, busy_e0}, 32'h0);
        wait_done();
        check("nodiv_no_done", {31'b0, done}, 32'h0);
        check("nodiv_hi", hi, 32'h0);
        check("nodiv_lo", lo, 32'h1C8CFC00);
`endif

        // MTHI while idle
        @(negedge clk); hi_we = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1;
        hi_we = 1'b0;
        check("mthi_idle", hi, 32'h12345678);
        @(negedge clk); lo_we = 1'b1; wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo_idle", lo, 32'h0BADF00D);

        // MTLO during busy is dropped
        issue(MULTU, 32'd3, 32'd4);
        repeat (3) @(posedge clk);
        @(negedge clk); lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo_busy_dropped", lo, 32'h0BADF00D);
        cyc = cyc + 4;
        wait_done();
        check("mtlo_busy_lo", lo, 32'd12);
        check("mtlo_busy_hi", hi, 32'd0);

        // MTHI in same cycle as start: write lands, result overwrites
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd6; b = 32'd7; hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; cyc = 1; bad_busy = 0;
        check("mthi_with_start", hi, 32'hAAAA5555);
        wait_done();
        check("mthi_overwritten", hi, 32'd0);
        check("mthi_start_lo", lo, 32'd42);

        // Reset mid-operation
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk); rst = 1'b0;
        bad_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) bad_busy++;
        end
        check("midrst_no_done", 32'(bad_busy), 32'd0);
        issue(MULTU, 32'd1234, 32'd5678);
        wait_done();
        check("postrst_latency", 32'(cyc), 32'd34);
        check("postrst_lo", lo, 32'd7006652);
        check("postrst_hi", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
